// File: rtl/drum_hit_detector.sv
// drum_hit_detector: per-channel piezo strike detector.
// Hysteresis trigger on 12-bit ADC samples, bounded peak capture, one-cycle
// HIT strobe with 8-bit velocity, holdoff and re-arm retrigger suppression,
// and a wrapping hit counter.
// Optional macro DRUM_LED_METER_EN: registered thermometer velocity meter on led.
module drum_hit_detector #(
  parameter logic [11:0] ON_THRESH       = 12'd800,
  parameter logic [11:0] OFF_THRESH      = 12'd400,
  parameter int unsigned PEAK_WIN        = 8,
  parameter int unsigned HOLDOFF_SAMPLES = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SAMPLE_VALID,
  input  logic [15:0] DATA,
  output logic        HIT,
  output logic [7:0]  VELOCITY,
  output logic [7:0]  HIT_CNT,
  output logic        BUSY,
  output logic [7:0]  led
);

  localparam logic [7:0] WinLast  = PEAK_WIN[7:0];
  localparam logic [9:0] HoldLast = HOLDOFF_SAMPLES[9:0];

  typedef enum logic [1:0] {
    StIdle,
    StAttack,
    StHoldoff,
    StRearm
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [11:0] r_peak, w_peak_nxt;
  logic [7:0]  r_win_cnt, w_win_cnt_nxt;
  logic [9:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic        r_hit, w_hit_nxt;
  logic [7:0]  r_vel, w_vel_nxt;
  logic [7:0]  r_hit_cnt, w_hit_cnt_nxt;

  logic [11:0] w_s;
  logic [11:0] w_peak_max;
  logic [7:0]  w_win_inc;
  logic [9:0]  w_hold_inc;
  logic        w_unused_data_hi;

  assign w_s              = DATA[11:0];
  assign w_unused_data_hi = ^DATA[15:12];
  // Running max includes the current sample so a terminating sample can still be the peak.
  assign w_peak_max       = (w_s > r_peak) ? w_s : r_peak;
  assign w_win_inc        = r_win_cnt + 8'd1;
  assign w_hold_inc       = r_hold_cnt + 10'd1;

  // Next-state and datapath decode; nothing moves unless a sample is valid, HIT self-clears.
  always_comb begin
    w_state_nxt    = r_state;
    w_peak_nxt     = r_peak;
    w_win_cnt_nxt  = r_win_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_hit_nxt      = 1'b0;
    w_vel_nxt      = r_vel;
    w_hit_cnt_nxt  = r_hit_cnt;
    if (SAMPLE_VALID) begin
      unique case (r_state)
        StIdle: begin
          if (w_s >= ON_THRESH) begin
            w_peak_nxt    = w_s;
            w_win_cnt_nxt = 8'd1;
            w_state_nxt   = StAttack;
          end
        end
        StAttack: begin
          w_peak_nxt    = w_peak_max;
          w_win_cnt_nxt = w_win_inc;
          if ((w_s < OFF_THRESH) || (w_win_inc == WinLast)) begin
            w_hit_nxt      = 1'b1;
            w_vel_nxt      = w_peak_max[11:4];
            w_hit_cnt_nxt  = r_hit_cnt + 8'd1;
            w_hold_cnt_nxt = '0;
            w_state_nxt    = StHoldoff;
          end
        end
        StHoldoff: begin
          w_hold_cnt_nxt = w_hold_inc;
          if (w_hold_inc == HoldLast) begin
            w_state_nxt = StRearm;
          end
        end
        StRearm: begin
          // Level must fall below OFF_THRESH before a new strike can arm.
          if (w_s < OFF_THRESH) begin
            w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= StIdle;
      r_peak     <= '0;
      r_win_cnt  <= '0;
      r_hold_cnt <= '0;
      r_hit      <= 1'b0;
      r_vel      <= '0;
      r_hit_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_peak     <= w_peak_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_hit      <= w_hit_nxt;
      r_vel      <= w_vel_nxt;
      r_hit_cnt  <= w_hit_cnt_nxt;
    end
  end

  assign HIT      = r_hit;
  assign VELOCITY = r_vel;
  assign HIT_CNT  = r_hit_cnt;
  assign BUSY     = (r_state != StIdle);

`ifdef DRUM_LED_METER_EN
  logic [7:0] r_led;
  logic [7:0] w_led_therm;

  // Thermometer of the new velocity: VELOCITY[7:5]+1 bits lit from bit 0.
  always_comb begin
    w_led_therm = '0;
    for (int i = 0; i < 8; i++) begin
      w_led_therm[i] = (i <= int'(w_vel_nxt[7:5]));
    end
  end

  // Meter register updates on the same edge as VELOCITY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_led <= '0;
    end else if (w_hit_nxt) begin
      r_led <= w_led_therm;
    end
  end

  assign led = r_led;
`else
  assign led = 8'h00;
`endif

endmodule

// File: tb/tb_drum_hit_detector.sv
// Self-checking bench for drum_hit_detector: directed vector table plus
// hand-written multi-cycle sequences (sustained level, retrigger, wrap, reset).
module tb_drum_hit_detector;

  logic        CLK;
  logic        RST_N;
  logic        SAMPLE_VALID;
  logic [15:0] DATA;
  logic        HIT;
  logic [7:0]  VELOCITY;
  logic [7:0]  HIT_CNT;
  logic        BUSY;
  logic [7:0]  led;

  int n_cmp = 0;
  int n_err = 0;
  int hit_pulses = 0;

  drum_hit_detector dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SAMPLE_VALID(SAMPLE_VALID),
    .DATA        (DATA),
    .HIT         (HIT),
    .VELOCITY    (VELOCITY),
    .HIT_CNT     (HIT_CNT),
    .BUSY        (BUSY),
    .led         (led)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // HIT is sampled mid-cycle so every pulse is seen exactly once.
  always @(negedge CLK) if (HIT) hit_pulses++;

  typedef struct {
    logic [15:0] data;
    logic        hit;
    logic        busy;
    logic [7:0]  cnt;
    logic [7:0]  vel;
  } vec_t;

  function automatic logic [7:0] exp_led(input logic [7:0] meter);
`ifdef DRUM_LED_METER_EN
    return meter;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One valid sample on the next edge; outputs are stable #1 after it.
  task automatic send(input logic [15:0] d);
    SAMPLE_VALID = 1'b1;
    DATA         = d;
    @(posedge CLK);
    #1;
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic do_reset();
    RST_N        = 1'b0;
    SAMPLE_VALID = 1'b0;
    DATA         = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  vec_t vecs[6];
  int   h0;
  int   first_hit_idx;

  initial begin
    vecs[0] = '{16'd100,  1'b0, 1'b0, 8'd0, 8'd0};
    vecs[1] = '{16'd900,  1'b0, 1'b1, 8'd0, 8'd0};
    vecs[2] = '{16'd1500, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[3] = '{16'd2400, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[4] = '{16'd1800, 1'b0, 1'b1, 8'd0, 8'd0};
    vecs[5] = '{16'd300,  1'b1, 1'b1, 8'd1, 8'd150};

    // Reset with samples pulsing at full scale.
    RST_N        = 1'b0;
    SAMPLE_VALID = 1'b0;
    DATA         = 16'h0FFF;
    for (int i = 0; i < 6; i++) begin
      SAMPLE_VALID = ~SAMPLE_VALID;
      @(posedge CLK);
    end
    #1;
    chk("rst_hit", int'(HIT), 0);
    chk("rst_vel", int'(VELOCITY), 0);
    chk("rst_cnt", int'(HIT_CNT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_led", int'(led), 0);
    SAMPLE_VALID = 1'b0;
    RST_N        = 1'b1;
    @(posedge CLK);
    #1;

    // Single strike from the vector table, consecutive valid samples.
    h0 = hit_pulses;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      chk($sformatf("vec%0d_hit", i), int'(HIT), int'(vecs[i].hit));
      chk($sformatf("vec%0d_busy", i), int'(BUSY), int'(vecs[i].busy));
      chk($sformatf("vec%0d_cnt", i), int'(HIT_CNT), int'(vecs[i].cnt));
      chk($sformatf("vec%0d_vel", i), int'(VELOCITY), int'(vecs[i].vel));
    end
    chk("single_led", int'(led), int'(exp_led(8'h1F)));
    @(posedge CLK);
    #1;
    chk("single_hit_clears", int'(HIT), 0);
    // Holdoff boundary: 32 samples in HOLDOFF, the 33rd (low) re-arms.
    for (int i = 0; i < 31; i++) send(16'd0);
    chk("hold31_busy", int'(BUSY), 1);
    send(16'd0);
    chk("hold32_busy", int'(BUSY), 1);
    send(16'd0);
    chk("rearm_idle", int'(BUSY), 0);
    chk("single_pulses", hit_pulses - h0, 1);

    // Sustained maximum: window closes on the 8th sample.
    do_reset();
    h0            = hit_pulses;
    first_hit_idx = -1;
    for (int i = 0; i < 60; i++) begin
      send(16'd4095);
      if (HIT && first_hit_idx < 0) first_hit_idx = i;
    end
    chk("sus_hit_idx", first_hit_idx, 7);
    chk("sus_vel", int'(VELOCITY), 255);
    chk("sus_led", int'(led), int'(exp_led(8'hFF)));
    chk("sus_busy", int'(BUSY), 1);
    send(16'd400);
    chk("sus_rearm_at_off", int'(BUSY), 1);
    send(16'd0);
    chk("sus_idle", int'(BUSY), 0);
    chk("sus_pulses", hit_pulses - h0, 1);
    chk("sus_cnt", int'(HIT_CNT), 1);

    // Retrigger suppression, then a small second strike.
    do_reset();
    h0 = hit_pulses;
    for (int i = 0; i < 6; i++) send(vecs[i].data);
    for (int i = 0; i < 4; i++) send(16'd0);
    send(16'd1500);
    chk("retrig_none", hit_pulses - h0, 1);
    chk("retrig_cnt", int'(HIT_CNT), 1);
    for (int i = 0; i < 27; i++) send(16'd1500);
    chk("retrig_rearm_busy", int'(BUSY), 1);
    send(16'd0);
    send(16'd900);
    chk("retrig_attack", int'(BUSY), 1);
    send(16'd200);
    chk("retrig2_hit", int'(HIT), 1);
    chk("retrig2_vel", int'(VELOCITY), 56);
    chk("retrig2_cnt", int'(HIT_CNT), 2);
    chk("retrig2_led", int'(led), int'(exp_led(8'h03)));

    // Counter wrap with strikes of exactly ON_THRESH.
    do_reset();
    h0 = hit_pulses;
    for (int k = 0; k < 256; k++) begin
      send(16'd800);
      send(16'd0);
      if (k == 0) begin
        chk("edge800_vel", int'(VELOCITY), 50);
        chk("edge800_cnt", int'(HIT_CNT), 1);
      end
      for (int i = 0; i < 33; i++) send(16'd0);
    end
    chk("wrap_cnt", int'(HIT_CNT), 0);
    chk("wrap_pulses", hit_pulses - h0, 256);
    chk("wrap_idle", int'(BUSY), 0);
    send(16'd799);
    chk("edge799_idle", int'(BUSY), 0);
    send(16'hF000);
    chk("upper_bits_idle", int'(BUSY), 0);
    send(16'd800);
    send(16'd400);
    chk("off_eq_no_end", int'(BUSY), 1);
    chk("off_eq_no_hit", int'(HIT), 0);
    send(16'd399);
    chk("off_below_hit", int'(HIT), 1);

    // Reset mid-strike discards the strike.
    do_reset();
    h0 = hit_pulses;
    send(16'd900);
    send(16'd1500);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_vel", int'(VELOCITY), 0);
    chk("midrst_cnt", int'(HIT_CNT), 0);
    send(16'd300);
    @(posedge CLK);
    #1;
    chk("midrst_pulses", hit_pulses - h0, 0);
    chk("midrst_idle", int'(BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
